// File: rtl/newton_raphson_divide_seq_16_if.sv
// Request/response bundle for the sequential Newton-Raphson divider.
// master drives start/n/d; slave returns ready/done/q/r/dbz.
interface newton_raphson_divide_seq_16_if;
   logic        start;
   logic [15:0] n;
   logic [15:0] d;
   logic        ready;
   logic        done;
   logic [15:0] q;
   logic [15:0] r;
   logic        dbz;

   modport master (
      output start, n, d,
      input  ready, done, q, r, dbz
   );

   modport slave (
      input  start, n, d,
      output ready, done, q, r, dbz
   );
endinterface

// File: rtl/newton_raphson_divide_seq_16.sv
// Sequential 16-bit unsigned Newton-Raphson divider, one shared multiplier.
// Ports: clk, rst_n (async, active low), bus (slave: start/n/d in, ready/done/q/r/dbz out).
module newton_raphson_divide_seq_16 #(
   parameter int ITERS = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   newton_raphson_divide_seq_16_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_NORM, S_EST, S_ITER,
      S_QMUL, S_CORR1, S_CORR2, S_DONE
   } state_t;

   // Reciprocal is Q2.22; 48/17 and 32/17 in the same format.
   localparam logic [23:0] K48 = 24'd11842741;
   localparam logic [23:0] C32 = 24'd7895160;
   localparam logic [23:0] TWO = 24'h800000;
   localparam logic [3:0]  ITER_LAST = 4'(2 * ITERS - 1);

   state_t      state_q, state_d;
   logic [15:0] n_q, n_d;
   logic [15:0] d_q, d_d;
   logic [3:0]  s_q, s_d;
   logic [15:0] dn_q, dn_d;
   logic [23:0] x_q, x_d;
   logic [23:0] e_q, e_d;
   logic [15:0] qe_q, qe_d;
   logic [17:0] rt_q, rt_d;
   logic [3:0]  it_q, it_d;
   logic [15:0] q_q, q_d;
   logic [15:0] r_q, r_d;
   logic        dbz_q, dbz_d;

   logic [23:0] mul_a, mul_b;
   logic [47:0] prod;
   logic [3:0]  lz;
   logic        accept;
   logic [17:0] d_ext;

   function automatic logic [3:0] lzc16(input logic [15:0] v);
      logic [3:0] c;
      c = 4'd15;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) c = 4'(15 - i);
      end
      return c;
   endfunction

   assign lz    = lzc16(d_q);
   assign d_ext = {2'b00, d_q};

   // The only multiplier; every stage steers its operands here.
   assign prod = {24'd0, mul_a} * {24'd0, mul_b};

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      unique case (state_q)
         S_NORM: begin
            mul_a = {8'd0, d_q};
            mul_b = 24'd1 << lz;
         end
         S_EST: begin
            mul_a = {8'd0, dn_q};
            mul_b = C32;
         end
         S_ITER: begin
            if (!it_q[0]) begin
               mul_a = {8'd0, dn_q};
               mul_b = x_q;
            end else begin
               mul_a = x_q;
               mul_b = e_q;
            end
         end
         S_QMUL: begin
            mul_a = {8'd0, n_q};
            mul_b = x_q;
         end
         S_CORR1: begin
            mul_a = {8'd0, qe_q};
            mul_b = {8'd0, d_q};
         end
         default: ;
      endcase
   end

   assign accept = bus.start &&
                   (state_q == S_IDLE || state_q == S_DONE);

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      d_d     = d_q;
      s_d     = s_q;
      dn_d    = dn_q;
      x_d     = x_q;
      e_d     = e_q;
      qe_d    = qe_q;
      rt_d    = rt_q;
      it_d    = it_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               n_d  = bus.n;
               d_d  = bus.d;
               it_d = '0;
               if (bus.d == 16'd0) begin
                  state_d = S_DONE;
                  q_d     = 16'hFFFF;
                  r_d     = bus.n;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_NORM;
               end
            end
         end
         S_NORM: begin
            s_d     = lz;
            dn_d    = prod[15:0];
            state_d = S_EST;
         end
         S_EST: begin
            x_d     = K48 - prod[39:16];
            state_d = S_ITER;
         end
         S_ITER: begin
            // Even step forms e = 2 - dn*x, odd step x = x*e.
            if (!it_q[0]) e_d = TWO - prod[39:16];
            else          x_d = prod[45:22];
            it_d = it_q + 4'd1;
            if (it_q == ITER_LAST) state_d = S_QMUL;
         end
         S_QMUL: begin
            // n*x carries 22 fraction bits; undo the 16-s normalisation.
            qe_d    = 16'(prod >> (6'd38 - {2'b00, s_q}));
            state_d = S_CORR1;
         end
         S_CORR1: begin
            rt_d    = {2'b00, n_q} - prod[17:0];
            state_d = S_CORR2;
         end
         S_CORR2: begin
            if (rt_q[17]) begin
               q_d = qe_q - 16'd1;
               r_d = 16'(rt_q + d_ext);
            end else if (rt_q >= d_ext) begin
               q_d = qe_q + 16'd1;
               r_d = 16'(rt_q - d_ext);
            end else begin
               q_d = qe_q;
               r_d = rt_q[15:0];
            end
            dbz_d   = 1'b0;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         d_q     <= '0;
         s_q     <= '0;
         dn_q    <= '0;
         x_q     <= '0;
         e_q     <= '0;
         qe_q    <= '0;
         rt_q    <= '0;
         it_q    <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         d_q     <= d_d;
         s_q     <= s_d;
         dn_q    <= dn_d;
         x_q     <= x_d;
         e_q     <= e_d;
         qe_q    <= qe_d;
         rt_q    <= rt_d;
         it_q    <= it_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.ready = (state_q == S_IDLE) || (state_q == S_DONE);
   assign bus.done  = (state_q == S_DONE);
   assign bus.q     = q_q;
   assign bus.r     = r_q;
   assign bus.dbz   = dbz_q;

endmodule

// File: tb/tb_newton_raphson_divide_seq_16.sv
// Scoreboard bench for newton_raphson_divide_seq_16.
// Stimulus pushes expected results; a negedge monitor pops on done.
module tb_newton_raphson_divide_seq_16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   newton_raphson_divide_seq_16_if bus();

   newton_raphson_divide_seq_16 #(.ITERS(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0 q=%0h",
                     bus.q);
         end else begin
            e = sb.pop_front();
            chk("q", {16'd0, bus.q}, {16'd0, e.q});
            chk("r", {16'd0, bus.r}, {16'd0, e.r});
            chk("dbz", {31'd0, bus.dbz}, {31'd0, e.dbz});
            chk("latency", cyc - e.acc, e.lat);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept.
   task automatic issue(input logic [15:0] nn, input logic [15:0] dd,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic ed);
      exp_t e;
      int   k;
      bus.start = 1'b1;
      bus.n     = nn;
      bus.d     = dd;
      k = 0;
      while (!bus.ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!bus.ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=busy required=ready");
         bus.start = 1'b0;
         return;
      end
      e.q   = eq;
      e.r   = er;
      e.dbz = ed;
      e.lat = (dd == 16'd0) ? 1 : 12;
      e.acc = cyc;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic drain();
      int k;
      bus.start = 1'b0;
      k = 0;
      while (sb.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=%0d required=0 pending",
                  sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
      chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
      chk({tag, "_q"}, {16'd0, bus.q}, 32'd0);
      chk({tag, "_r"}, {16'd0, bus.r}, 32'd0);
      chk({tag, "_dbz"}, {31'd0, bus.dbz}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rn, rd;
      bus.start = 1'b0;
      bus.n     = '0;
      bus.d     = '0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;

      // first accept on the first edge after release; operands then change
      issue(16'd18, 16'd3, 16'd6, 16'd0, 1'b0);
      bus.start = 1'b0;
      bus.n     = 16'hAAAA;
      bus.d     = 16'd0;
      drain();

      issue(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
      drain();
      issue(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
      drain();
      issue(16'h8000, 16'hFFFF, 16'd0, 16'h8000, 1'b0);
      drain();
      issue(16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);
      drain();
      issue(16'd0, 16'd5, 16'd0, 16'd0, 1'b0);
      drain();

      // divide by zero, then a normal op accepted in its DONE cycle
      issue(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
      issue(16'd9, 16'd2, 16'd4, 16'd1, 1'b0);
      drain();

      // back-to-back with start held; busy-cycle starts must be ignored
      issue(16'd100, 16'd9, 16'd11, 16'd1, 1'b0);
      issue(16'd77, 16'd11, 16'd7, 16'd0, 1'b0);
      issue(16'd65535, 16'd255, 16'd257, 16'd0, 1'b0);
      drain();

      // reset mid-operation aborts without a done
      issue(16'd200, 16'd3, 16'd66, 16'd2, 1'b0);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      repeat (3) @(negedge clk);
      chk_reset_vals("midreset");
      repeat (20) @(negedge clk);
      rst_n = 1'b1;
      issue(16'd200, 16'd3, 16'd66, 16'd2, 1'b0);
      drain();

      for (int i = 0; i < 300; i++) begin
         rn = 16'($urandom);
         if (i % 4 == 0) rd = 16'($urandom_range(1, 15));
         else            rd = 16'($urandom_range(1, 65535));
         issue(rn, rd, rn / rd, rn % rd, 1'b0);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
